fft_wb_addr_gen: RTL and testbench
==================================

FFT_WB_ADDR_GEN -- requirements
Module: fft_wb_addr_gen

Interface
REQ-001 Parameter STAGE, default 2, meaning FFT stage number (1..SIZE); butterfly span = 2^(STAGE-1).
REQ-002 Parameter N, default 16, meaning FFT length (power of two); N/2 butterfly pairs per stage.
REQ-003 Parameter SIZE, default 4, meaning log2(N); memory address width.
REQ-004 Parameter DW, default 32, meaning width of one complex sample word (re/im packed).
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_stage  input  1  single-cycle pulse starting write-back of one stage.
REQ-008 bf_valid  input  1  butterfly result pair present on bf_data_a/bf_data_b.
REQ-009 bf_data_a  input  DW  butterfly upper output (x + W*y).
REQ-010 bf_data_b  input  DW  butterfly lower output (x - W*y).
REQ-011 bf_ready  output  1  block accepts a result pair this cycle.
REQ-012 wr_en  output  1  memory write strobe.
REQ-013 wr_ptr  output  SIZE  memory write address.
REQ-014 wr_data  output  DW  memory write data.
REQ-015 stage_done  output  1  single-cycle pulse, all N words of stage written.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, WR_A, WR_B, DONE; all outputs registered.
REQ-017 IDLE -> WAIT on start_stage; start_stage in any other state SHALL be ignored.
REQ-018 Handshake: pair accepted in a cycle where bf_valid && bf_ready; bf_data_a/b captured into internal holding registers on that edge.
REQ-019 bf_ready SHALL be 1 in WAIT, and in WR_B unless the pair being written is pair N/2-1; 0 in all other states.
REQ-020 Accept in WAIT or WR_B -> WR_A next; WR_A -> WR_B unconditionally; WR_B without accept -> WAIT if pairs remain, else DONE; DONE -> IDLE.
REQ-021 Pair counter p (SIZE-1 bits) SHALL start at 0 on start_stage and increment after each WR_B.
REQ-022 Address rule: k = p mod 2^(STAGE-1), g = p >> (STAGE-1); addr_a = g*2^STAGE + k; addr_b = addr_a + 2^(STAGE-1); STAGE=1 SHALL give addr_a = 2p, addr_b = 2p+1.
REQ-023 In WR_A cycle: wr_en=1, wr_ptr=addr_a, wr_data=captured a; in WR_B cycle: wr_en=1, wr_ptr=addr_b, wr_data=captured b; wr_en=0 in all other states.
REQ-024 Latency: pair accepted in cycle c SHALL produce write A in c+1 and write B in c+2; sustained throughput one pair per 2 cycles.
REQ-025 stage_done SHALL be 1 for exactly the single DONE cycle, immediately after write B of pair N/2-1.
REQ-026 bf_valid in IDLE or DONE SHALL be ignored (no capture, no write); held bf_valid with bf_ready=0 SHALL not lose the pair.
REQ-027 Exactly N writes per stage, each address 0..N-1 written exactly once; no write after stage_done until next start_stage.

Reset
REQ-028 On rst_n=0 the block SHALL enter IDLE asynchronously: bf_ready=0, wr_en=0, wr_ptr=0, wr_data=0, stage_done=0, p=0, holding registers 0.
REQ-029 Reset asserted mid-stage SHALL abort the stage with no further writes and no stage_done; a new start_stage after release SHALL restart at p=0.

Verification
REQ-030 N=16, STAGE=2, bf_valid held 1: wr_ptr sequence 0,2,1,3,4,6,5,7,8,10,9,11,12,14,13,15; wr_en high 16 consecutive cycles; stage_done one cycle after write to 15.
REQ-031 STAGE=1: writes 0,1,2,...,15 in order; STAGE=4: writes 0,8,1,9,...,7,15; wr_data matches a/b of the corresponding accepted pair.
REQ-032 bf_valid toggling 1,0,0,1: each accepted pair written in next two cycles, wr_en gaps while in WAIT, no pair dropped or duplicated.
REQ-033 bf_valid=1 before start_stage and after stage_done: no writes, bf_ready=0; second start_stage mid-stage: no effect on sequence.
REQ-034 rst_n pulsed low after pair 3 write A: wr_en drops immediately, no stage_done; restart yields full 16-write sequence from address 0.

Source files
------------

// File: rtl/fft_wb_addr_gen.sv
// FFT stage write-back: takes butterfly result pairs and writes them to the
// stage's data memory at the two addresses of the butterfly (span 2^(STAGE-1)).
module fft_wb_addr_gen #(
    parameter int STAGE = 2,
    parameter int N     = 16,
    parameter int SIZE  = 4,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_stage,
    input  logic            bf_valid,
    input  logic [DW-1:0]   bf_data_a,
    input  logic [DW-1:0]   bf_data_b,
    output logic            bf_ready,
    output logic            wr_en,
    output logic [SIZE-1:0] wr_ptr,
    output logic [DW-1:0]   wr_data,
    output logic            stage_done,
    output logic [2:0]      state_dbg
);

    // Handshake: a result pair moves on a rising edge where bf_valid && bf_ready.
    // bf_ready never depends on bf_valid, and a producer holding bf_valid while
    // bf_ready is low keeps its pair until a later edge takes it.

    typedef enum logic [2:0] {IDLE, WAIT, WR_A, WR_B, DONE} state_t;

    localparam logic [SIZE-2:0] LAST_P = (SIZE-1)'(N/2 - 1);
    localparam logic [SIZE-1:0] SPAN   = SIZE'(1 << (STAGE - 1));

    state_t          state;
    logic [SIZE-2:0] p;
    logic [SIZE-2:0] p_next;
    logic [DW-1:0]   hold_a;
    logic [DW-1:0]   hold_b;

    // Upper address of pair pp: group index shifted past the butterfly span,
    // offset within the group in the low STAGE-1 bits.
    function automatic logic [SIZE-1:0] addr_a_of(input logic [SIZE-2:0] pp);
        logic [SIZE-1:0] pe;
        logic [SIZE-1:0] k;
        logic [SIZE-1:0] g;
        pe = {1'b0, pp};
        k  = pe & (SPAN - 1'b1);
        g  = pe >> (STAGE - 1);
        return (g << STAGE) | k;
    endfunction

    assign p_next    = p + 1'b1;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            p          <= '0;
            hold_a     <= '0;
            hold_b     <= '0;
            bf_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_ptr     <= '0;
            wr_data    <= '0;
            stage_done <= 1'b0;
        end else begin
            bf_ready   <= 1'b0;
            wr_en      <= 1'b0;
            stage_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_stage) begin
                        state    <= WAIT;
                        p        <= '0;
                        bf_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bf_valid && bf_ready) begin
                        hold_a  <= bf_data_a;
                        hold_b  <= bf_data_b;
                        state   <= WR_A;
                        wr_en   <= 1'b1;
                        wr_ptr  <= addr_a_of(p);
                        wr_data <= bf_data_a;
                    end else begin
                        bf_ready <= 1'b1;
                    end
                end
                WR_A: begin
                    state    <= WR_B;
                    wr_en    <= 1'b1;
                    wr_ptr   <= addr_a_of(p) | SPAN;
                    wr_data  <= hold_b;
                    // The last pair of the stage must not admit another one.
                    bf_ready <= (p != LAST_P);
                end
                WR_B: begin
                    p <= p_next;
                    if (bf_valid && bf_ready) begin
                        hold_a  <= bf_data_a;
                        hold_b  <= bf_data_b;
                        state   <= WR_A;
                        wr_en   <= 1'b1;
                        wr_ptr  <= addr_a_of(p_next);
                        wr_data <= bf_data_a;
                    end else if (p == LAST_P) begin
                        state      <= DONE;
                        stage_done <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        bf_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_wb_addr_gen.sv
// Bench for fft_wb_addr_gen: three instances (STAGE 1, 2, 4) share stimulus and
// are checked every cycle against a pending-write queue model.
module tb_fft_wb_addr_gen;

    localparam int N    = 16;
    localparam int SIZE = 4;
    localparam int DW   = 32;
    localparam int NP   = N / 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_stage = 1'b0;
    logic            bf_valid = 1'b0;
    logic [DW-1:0]   bf_data_a = '0;
    logic [DW-1:0]   bf_data_b = '0;
    logic [2:0]      bf_ready;
    logic [2:0]      wr_en;
    logic [2:0]      stage_done;
    logic [SIZE-1:0] wr_ptr [3];
    logic [DW-1:0]   wr_data [3];
    logic [2:0]      state_dbg [3];

    always #5 clk = ~clk;

    fft_wb_addr_gen #(.STAGE(1), .N(N), .SIZE(SIZE), .DW(DW)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start_stage(start_stage), .bf_valid(bf_valid),
        .bf_data_a(bf_data_a), .bf_data_b(bf_data_b), .bf_ready(bf_ready[0]),
        .wr_en(wr_en[0]), .wr_ptr(wr_ptr[0]), .wr_data(wr_data[0]),
        .stage_done(stage_done[0]), .state_dbg(state_dbg[0]));
    fft_wb_addr_gen #(.STAGE(2), .N(N), .SIZE(SIZE), .DW(DW)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start_stage(start_stage), .bf_valid(bf_valid),
        .bf_data_a(bf_data_a), .bf_data_b(bf_data_b), .bf_ready(bf_ready[1]),
        .wr_en(wr_en[1]), .wr_ptr(wr_ptr[1]), .wr_data(wr_data[1]),
        .stage_done(stage_done[1]), .state_dbg(state_dbg[1]));
    fft_wb_addr_gen #(.STAGE(4), .N(N), .SIZE(SIZE), .DW(DW)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start_stage(start_stage), .bf_valid(bf_valid),
        .bf_data_a(bf_data_a), .bf_data_b(bf_data_b), .bf_ready(bf_ready[2]),
        .wr_en(wr_en[2]), .wr_ptr(wr_ptr[2]), .wr_data(wr_data[2]),
        .stage_done(stage_done[2]), .state_dbg(state_dbg[2]));

    // Hand-written write orders for STAGE 1, 2 and 4.
    int seq_lit [3][16] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
        '{0, 2, 1, 3, 4, 6, 5, 7, 8, 10, 9, 11, 12, 14, 13, 15},
        '{0, 8, 1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14, 7, 15}
    };

    typedef struct {
        int          p;
        bit          is_b;
        logic [31:0] data;
    } wr_t;

    wr_t             pend[$];
    wr_t             w;
    bit              m_busy = 1'b0;
    bit              m_done = 1'b0;
    int              m_acc = 0;
    bit              exp_ready, acc, popped, busy_cur;
    int              n_chk = 0;
    int              n_fail = 0;
    int              done_cnt = 0;
    int              run = 0;
    bit              held_phase = 1'b0;
    bit              vpat_mode = 1'b0;
    int              cyc = 0;
    int              act_log [3][32];
    int              act_n [3] = '{0, 0, 0};
    bit              prev_en [3] = '{0, 0, 0};
    logic [SIZE-1:0] prev_ptr [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int stg(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // The butterflies of a stage pair i with i+h for every i whose bit h is
    // clear; pair p is the p-th such i in ascending order.
    function automatic int pair_addr(input int stage, input int pp, input bit is_b);
        int h;
        int cnt;
        int r;
        h = 1 << (stage - 1);
        cnt = 0;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if ((i & h) == 0) begin
                if (cnt == pp) r = is_b ? i + h : i;
                cnt++;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                chk("rst_ready", bf_ready[k], 0);
                chk("rst_wr_en", wr_en[k], 0);
                chk("rst_done", stage_done[k], 0);
                chk("rst_wr_ptr", wr_ptr[k], 0);
                chk("rst_wr_data", wr_data[k], 0);
                prev_en[k] = 1'b0;
            end
            pend.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_acc  = 0;
            run    = 0;
        end else begin
            exp_ready = m_busy && (m_acc < NP) && (pend.size() <= 1);
            for (int k = 0; k < 3; k++) begin
                chk("ready", bf_ready[k], exp_ready);
                chk("wr_en", wr_en[k], pend.size() > 0);
                chk("stage_done", stage_done[k], m_done);
                if (pend.size() > 0) begin
                    chk("wr_ptr", wr_ptr[k], pair_addr(stg(k), pend[0].p, pend[0].is_b));
                    chk("wr_data", wr_data[k], pend[0].data);
                end
                if (wr_en[k] && act_n[k] < 32) begin
                    act_log[k][act_n[k]] = int'(wr_ptr[k]);
                    act_n[k]++;
                end
                if (stage_done[k]) begin
                    chk("done_after_wr", prev_en[k], 1);
                    chk("done_after_15", prev_ptr[k], N - 1);
                end
                prev_en[k]  = wr_en[k];
                prev_ptr[k] = wr_ptr[k];
            end
            if (stage_done[1]) begin
                done_cnt++;
                if (held_phase) chk("wr_en_run16", run, 16);
            end
            run = wr_en[1] ? run + 1 : 0;

            busy_cur = m_busy;
            acc      = bf_valid && exp_ready;
            popped   = pend.size() > 0;
            if (popped) void'(pend.pop_front());
            if (acc) begin
                w.p = m_acc; w.is_b = 1'b0; w.data = bf_data_a;
                pend.push_back(w);
                w.is_b = 1'b1; w.data = bf_data_b;
                pend.push_back(w);
                m_acc++;
            end
            if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (popped && pend.size() == 0 && m_acc == NP) begin
                m_done = 1'b1;
            end
            if (start_stage && !busy_cur) begin
                m_busy = 1'b1;
                m_acc  = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            bf_data_a = 32'hA000_0000 + 32'(cyc);
            bf_data_b = 32'hB000_0000 + 32'(cyc);
            if (vpat_mode) bf_valid = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        end
    endtask

    task automatic pulse_start();
        start_stage = 1'b1;
        step(1);
        start_stage = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int c0;
        int i;
        c0 = done_cnt;
        i = 0;
        while (done_cnt == c0 && i < limit) begin
            step(1);
            i++;
        end
        chk(name, done_cnt, c0 + 1);
    endtask

    task automatic check_phase(input string name, input int n_exp);
        for (int k = 0; k < 3; k++) begin
            chk({name, "_count"}, act_n[k], n_exp);
            for (int i = 0; i < n_exp && i < act_n[k]; i++)
                chk({name, "_addr"}, act_log[k][i], seq_lit[k][i]);
            act_n[k] = 0;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int pp = 0; pp < NP; pp++) begin
                chk("model_addr_a", pair_addr(stg(k), pp, 1'b0), seq_lit[k][2*pp]);
                chk("model_addr_b", pair_addr(stg(k), pp, 1'b1), seq_lit[k][2*pp+1]);
            end

        step(3);
        rst_n = 1'b1;
        bf_valid = 1'b1;
        step(4);
        check_phase("pre_start", 0);

        // Held valid, with a second start pulse in the middle of the stage.
        held_phase = 1'b1;
        pulse_start();
        step(5);
        pulse_start();
        wait_done("done_held", 60);
        step(5);
        check_phase("held", 16);

        // Valid toggling 1,0,0,1.
        held_phase = 1'b0;
        vpat_mode = 1'b1;
        pulse_start();
        wait_done("done_toggle", 150);
        vpat_mode = 1'b0;
        bf_valid = 1'b0;
        step(4);
        check_phase("toggle", 16);

        // Reset right after write A of pair 3.
        bf_valid = 1'b1;
        pulse_start();
        step(8);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(6);
        check_phase("aborted", 7);
        chk("no_done_on_abort", done_cnt, 2);

        held_phase = 1'b1;
        pulse_start();
        wait_done("done_restart", 60);
        step(3);
        check_phase("restart", 16);
        chk("done_total", done_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
